escalonador_acesso: RTL and testbench

Sequential slot scheduler downstream of the combinational priority stage (TV > PC > Alexa). It takes that stage's one-hot priority result plus the raw request lines and issues a registered one-hot grant held for a fixed time slot. It adds a starvation override so PC/Alexa are served even under continuous higher-priority load, and it keeps per-device served counters.

---
 rtl/escalonador_acesso_pkg.sv | 28 ++
 rtl/escalonador_acesso_contador_saturado.sv | 35 +++
 rtl/escalonador_acesso.sv | 155 +++++++++++++++
 tb/tb_escalonador_acesso.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_acesso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : escalonador_acesso_pkg
// Brief    : Shared state encodings, device indices and pedido decoder.
// Revision : 1.0
// ============================================================================
package escalonador_acesso_pkg;

    localparam logic [1:0] c_ocioso    = 2'd0;
    localparam logic [1:0] c_concedido = 2'd1;
    localparam logic [1:0] c_intervalo = 2'd2;

    localparam int c_idx_tv    = 2;
    localparam int c_idx_pc    = 1;
    localparam int c_idx_alexa = 0;

    // Reduces a possibly non-one-hot pedido to one-hot, TV > PC > Alexa.
    function automatic logic [2:0] decodifica(input logic [2:0] p);
        logic [2:0] r;
        r = 3'b000;
        if (p[c_idx_tv])         r = 3'b100;
        else if (p[c_idx_pc])    r = 3'b010;
        else if (p[c_idx_alexa]) r = 3'b001;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/escalonador_acesso_contador_saturado.sv
`default_nettype none
// ============================================================================
// Module   : contador_saturado
// Brief    : Up-counter that holds at MAXIMO; clear has priority over inc.
// Revision : 1.0
// ============================================================================
module contador_saturado #(
    parameter int LARGURA = 8,
    parameter int MAXIMO  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [LARGURA-1:0] o_valor
);

    localparam logic [LARGURA-1:0] c_max = LARGURA'(MAXIMO);

    logic [LARGURA-1:0] r_valor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valor <= '0;
        end else if (i_clr) begin
            r_valor <= '0;
        end else if (i_inc && (r_valor != c_max)) begin
            r_valor <= r_valor + LARGURA'(1);
        end
    end

    assign o_valor = r_valor;

endmodule
`default_nettype wire

// File: rtl/escalonador_acesso.sv
`default_nettype none
// ============================================================================
// Module   : escalonador_acesso
// Brief    : Slot scheduler with starvation override and served counters.
// Revision : 1.0
// ============================================================================
module escalonador_acesso
    import escalonador_acesso_pkg::*;
#(
    parameter int FATIA      = 4,
    parameter int MAX_ESPERA = 16,
    parameter int LARG_CONT  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   pedido,
    input  logic [2:0]                   pendente,
    output logic [2:0]                   concessao,
    output logic                         ocupado,
    output logic [$clog2(FATIA+1)-1:0]   fatia_rest,
    output logic                         forcado,
    output logic [LARG_CONT-1:0]         cont_tv,
    output logic [LARG_CONT-1:0]         cont_pc,
    output logic [LARG_CONT-1:0]         cont_alexa
);

    localparam int c_larg_fatia  = $clog2(FATIA+1);
    localparam int c_larg_espera = $clog2(MAX_ESPERA+1);
    localparam logic [c_larg_fatia-1:0]  c_fatia      = c_larg_fatia'(FATIA);
    localparam logic [c_larg_fatia-1:0]  c_um         = c_larg_fatia'(1);
    localparam logic [c_larg_espera-1:0] c_espera_max = c_larg_espera'(MAX_ESPERA);

    logic [1:0]               r_estado;
    logic [c_larg_espera-1:0] w_espera_pc;
    logic [c_larg_espera-1:0] w_espera_alexa;
    logic                     w_faminto_pc;
    logic                     w_faminto_alexa;
    logic [2:0]               w_vencedor;
    logic                     w_forca;
    logic                     w_inicia;
    logic                     w_fim;
    logic [LARG_CONT-1:0]     w_servidos [3];

    assign w_faminto_pc    = pendente[c_idx_pc]    && (w_espera_pc    == c_espera_max);
    assign w_faminto_alexa = pendente[c_idx_alexa] && (w_espera_alexa == c_espera_max);

    always_comb begin
        w_vencedor = 3'b000;
        w_forca    = 1'b0;
        if (w_faminto_pc) begin
            w_vencedor = 3'b010;
            w_forca    = 1'b1;
        end else if (w_faminto_alexa) begin
            w_vencedor = 3'b001;
            w_forca    = 1'b1;
        end else begin
            w_vencedor = decodifica(pedido);
        end
    end

    assign w_inicia = (r_estado != c_concedido) && (|w_vencedor);
    // Slot closes on its last cycle or as soon as the holder withdraws.
    assign w_fim    = (r_estado == c_concedido) &&
                      ((fatia_rest == c_um) || !(|(pendente & concessao)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado   <= c_ocioso;
            concessao  <= 3'b000;
            ocupado    <= 1'b0;
            fatia_rest <= '0;
            forcado    <= 1'b0;
        end else begin
            case (r_estado)
                c_ocioso, c_intervalo: begin
                    if (w_inicia) begin
                        r_estado   <= c_concedido;
                        concessao  <= w_vencedor;
                        ocupado    <= 1'b1;
                        fatia_rest <= c_fatia;
                        forcado    <= w_forca;
                    end else begin
                        r_estado   <= c_ocioso;
                        concessao  <= 3'b000;
                        ocupado    <= 1'b0;
                        fatia_rest <= '0;
                        forcado    <= 1'b0;
                    end
                end
                c_concedido: begin
                    if (w_fim) begin
                        r_estado   <= c_intervalo;
                        concessao  <= 3'b000;
                        ocupado    <= 1'b1;
                        fatia_rest <= '0;
                        forcado    <= 1'b0;
                    end else begin
                        fatia_rest <= fatia_rest - c_um;
                    end
                end
                default: begin
                    r_estado   <= c_ocioso;
                    concessao  <= 3'b000;
                    ocupado    <= 1'b0;
                    fatia_rest <= '0;
                    forcado    <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_servidos
            contador_saturado #(
                .LARGURA (LARG_CONT),
                .MAXIMO  ((1 << LARG_CONT) - 1)
            ) u_servido (
                .clk     (clk),
                .rst     (rst),
                .i_inc   (w_fim && concessao[i]),
                .i_clr   (1'b0),
                .o_valor (w_servidos[i])
            );
        end
    endgenerate

    assign cont_tv    = w_servidos[c_idx_tv];
    assign cont_pc    = w_servidos[c_idx_pc];
    assign cont_alexa = w_servidos[c_idx_alexa];

    // Waiting time restarts whenever the device is served or withdraws.
    contador_saturado #(
        .LARGURA (c_larg_espera),
        .MAXIMO  (MAX_ESPERA)
    ) u_espera_pc (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (pendente[c_idx_pc] && !concessao[c_idx_pc]),
        .i_clr   (!pendente[c_idx_pc] || (w_inicia && w_vencedor[c_idx_pc])),
        .o_valor (w_espera_pc)
    );

    contador_saturado #(
        .LARGURA (c_larg_espera),
        .MAXIMO  (MAX_ESPERA)
    ) u_espera_alexa (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (pendente[c_idx_alexa] && !concessao[c_idx_alexa]),
        .i_clr   (!pendente[c_idx_alexa] || (w_inicia && w_vencedor[c_idx_alexa])),
        .o_valor (w_espera_alexa)
    );

endmodule
`default_nettype wire

// File: tb/tb_escalonador_acesso.sv
`default_nettype none
// ============================================================================
// Module   : tb_escalonador_acesso
// Brief    : Directed, table-driven checks of the slot scheduler.
// Revision : 1.0
// ============================================================================
module tb_escalonador_acesso;

    logic       clk;
    logic       rst;
    logic [2:0] pedido;
    logic [2:0] pendente;
    logic [2:0] concessao;
    logic       ocupado;
    logic [2:0] fatia_rest;
    logic       forcado;
    logic [7:0] cont_tv;
    logic [7:0] cont_pc;
    logic [7:0] cont_alexa;

    int n_testes = 0;
    int n_falhas = 0;

    typedef struct {
        logic [2:0] ped;
        logic [2:0] pen;
        logic [2:0] conc;
        logic       ocu;
        logic [2:0] fat;
        logic       forc;
        logic [7:0] ctv;
        logic [7:0] cpc;
        logic [7:0] cal;
    } vetor_t;

    vetor_t tab [17];

    escalonador_acesso #(
        .FATIA      (4),
        .MAX_ESPERA (16),
        .LARG_CONT  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pedido     (pedido),
        .pendente   (pendente),
        .concessao  (concessao),
        .ocupado    (ocupado),
        .fatia_rest (fatia_rest),
        .forcado    (forcado),
        .cont_tv    (cont_tv),
        .cont_pc    (cont_pc),
        .cont_alexa (cont_alexa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_testes++;
        if (atual !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic passo;
        @(posedge clk);
        #1;
    endtask

    task automatic reinicia;
        pedido   = 3'b000;
        pendente = 3'b000;
        rst      = 1'b1;
        passo();
        passo();
        rst      = 1'b0;
    endtask

    int primeiro;

    initial begin
        // Test-2 sequence followed by priority decode and early-withdraw rows
        tab[0]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd4, 1'b0, 8'd0, 8'd0, 8'd0};
        tab[1]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd3, 1'b0, 8'd0, 8'd0, 8'd0};
        tab[2]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd2, 1'b0, 8'd0, 8'd0, 8'd0};
        tab[3]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd1, 1'b0, 8'd0, 8'd0, 8'd0};
        tab[4]  = '{3'b100, 3'b100, 3'b000, 1'b1, 3'd0, 1'b0, 8'd1, 8'd0, 8'd0};
        tab[5]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd4, 1'b0, 8'd1, 8'd0, 8'd0};
        tab[6]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd3, 1'b0, 8'd1, 8'd0, 8'd0};
        tab[7]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd2, 1'b0, 8'd1, 8'd0, 8'd0};
        tab[8]  = '{3'b100, 3'b100, 3'b100, 1'b1, 3'd1, 1'b0, 8'd1, 8'd0, 8'd0};
        tab[9]  = '{3'b000, 3'b000, 3'b000, 1'b1, 3'd0, 1'b0, 8'd2, 8'd0, 8'd0};
        tab[10] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 8'd2, 8'd0, 8'd0};
        tab[11] = '{3'b011, 3'b011, 3'b010, 1'b1, 3'd4, 1'b0, 8'd2, 8'd0, 8'd0};
        tab[12] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'd0, 1'b0, 8'd2, 8'd1, 8'd0};
        tab[13] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 8'd2, 8'd1, 8'd0};
        tab[14] = '{3'b001, 3'b000, 3'b001, 1'b1, 3'd4, 1'b0, 8'd2, 8'd1, 8'd0};
        tab[15] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'd0, 1'b0, 8'd2, 8'd1, 8'd1};
        tab[16] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 8'd2, 8'd1, 8'd1};

        // Idle after reset
        reinicia();
        chk("t1_forcado", forcado, 0);
        chk("t1_cont_tv", cont_tv, 0);
        chk("t1_cont_pc", cont_pc, 0);
        chk("t1_cont_alexa", cont_alexa, 0);
        for (int c = 0; c < 20; c++) begin
            passo();
            chk($sformatf("t1_conc_%0d", c), concessao, 0);
            chk($sformatf("t1_ocup_%0d", c), ocupado, 0);
            chk($sformatf("t1_fat_%0d", c), fatia_rest, 0);
        end

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            pedido   = tab[i].ped;
            pendente = tab[i].pen;
            passo();
            chk($sformatf("tab%0d_conc", i), concessao, tab[i].conc);
            chk($sformatf("tab%0d_ocup", i), ocupado, tab[i].ocu);
            chk($sformatf("tab%0d_fat", i), fatia_rest, tab[i].fat);
            chk($sformatf("tab%0d_forc", i), forcado, tab[i].forc);
            chk($sformatf("tab%0d_ctv", i), cont_tv, tab[i].ctv);
            chk($sformatf("tab%0d_cpc", i), cont_pc, tab[i].cpc);
            chk($sformatf("tab%0d_cal", i), cont_alexa, tab[i].cal);
        end

        // PC slot is not preempted by TV
        reinicia();
        pedido = 3'b010; pendente = 3'b010;
        passo(); chk("t3_conc1", concessao, 3'b010);
        passo(); chk("t3_conc2", concessao, 3'b010);
        pedido = 3'b100; pendente = 3'b110;
        passo(); chk("t3_conc3", concessao, 3'b010); chk("t3_fat3", fatia_rest, 2);
        passo(); chk("t3_conc4", concessao, 3'b010); chk("t3_fat4", fatia_rest, 1);
        passo(); chk("t3_interv", concessao, 3'b000); chk("t3_ocup", ocupado, 1);
        chk("t3_cont_pc", cont_pc, 1);
        passo(); chk("t3_tv", concessao, 3'b100); chk("t3_tv_fat", fatia_rest, 4);

        // TV withdraws mid-slot
        reinicia();
        pedido = 3'b100; pendente = 3'b100;
        passo(); chk("t5_conc1", concessao, 3'b100);
        passo(); chk("t5_conc2", concessao, 3'b100);
        pedido = 3'b000; pendente = 3'b000;
        passo(); chk("t5_fim", concessao, 3'b000); chk("t5_ocup_int", ocupado, 1);
        chk("t5_cont_tv", cont_tv, 1);
        passo(); chk("t5_ocioso", ocupado, 0);

        // Alexa starvation override under continuous TV load
        reinicia();
        pedido = 3'b100; pendente = 3'b101;
        primeiro = 0;
        for (int n = 1; n <= 40; n++) begin
            passo();
            if (concessao == 3'b001) begin
                primeiro = n;
                break;
            end
        end
        chk("t4_ciclo", primeiro, 21);
        chk("t4_forcado", forcado, 1);
        chk("t4_cont_tv", cont_tv, 4);
        chk("t4_fat0", fatia_rest, 4);
        for (int k = 1; k < 4; k++) begin
            passo();
            chk($sformatf("t4_conc_%0d", k), concessao, 3'b001);
            chk($sformatf("t4_fat_%0d", k), fatia_rest, 4 - k);
        end
        passo(); chk("t4_interv", concessao, 3'b000); chk("t4_cont_alexa", cont_alexa, 1);
        chk("t4_forc_lim", forcado, 0);
        passo(); chk("t4_tv_volta", concessao, 3'b100); chk("t4_tv_forc", forcado, 0);

        // Asynchronous reset mid-slot
        passo(); chk("t6_pre", fatia_rest, 3);
        #3 rst = 1'b1;
        #1;
        chk("t6_conc", concessao, 0);
        chk("t6_ocup", ocupado, 0);
        chk("t6_fat", fatia_rest, 0);
        chk("t6_forc", forcado, 0);
        chk("t6_ctv", cont_tv, 0);
        chk("t6_cal", cont_alexa, 0);
        pedido = 3'b010; pendente = 3'b010;
        #2 rst = 1'b0;
        passo(); chk("t6_grant", concessao, 3'b010); chk("t6_grant_fat", fatia_rest, 4);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
`default_nettype wire
